mem_arbiter: RTL and testbench

//  Shares the single four-banked main memory between the instruction-cache controller (port 0) and the

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/dff.sv | 25 ++
 rtl/rd_tag_pipe.sv | 59 +++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the main-memory arbiter: FSM state encodings and the
// requester port identifiers used for grant bookkeeping and read tagging.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GNT0  = 2'b01,
      ST_GNT1  = 2'b10,
      ST_DRAIN = 2'b11
   } arb_state_e;

   // Port IDs: port 0 is the instruction-cache side, port 1 the data-cache side.
   localparam logic PORT_IC = 1'b0;
   localparam logic PORT_DC = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/dff.sv
// ----------------------------------------------------------------------------
// dff
// Generic register cell with synchronous active-high reset to RST_VAL.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-high reset (tie low for data-only regs)
//   d_i  in  W  next-state value
//   q_o  out W  registered value
// ----------------------------------------------------------------------------
module dff #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (rst) q_o <= RST_VAL;
      else     q_o <= d_i;
   end

endmodule : dff

// File: rtl/rd_tag_pipe.sv
// ----------------------------------------------------------------------------
// rd_tag_pipe
// RD_LAT-deep shift register of {valid, port} tags. A tag pushed in cycle t
// appears on pop_* in cycle t+RD_LAT, aligned with the memory's read data.
// Ports:
//   clk        in  1  clock
//   rst        in  1  synchronous active-high reset (clears all valid bits)
//   push_i     in  1  a read was accepted by memory this cycle
//   port_i     in  1  port that issued the accepted read
//   pop_vld_o  out 1  read data for a tagged read is on the memory bus now
//   pop_port_o out 1  port that owns the read data currently returning
//   empty_o    out 1  no read is in flight
// ----------------------------------------------------------------------------
module rd_tag_pipe #(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic port_i,
   output logic pop_vld_o,
   output logic pop_port_o,
   output logic empty_o
);

   logic [RD_LAT-1:0] vld_q,  vld_d;
   logic [RD_LAT-1:0] port_q, port_d;

   always_comb begin
      vld_d     = '0;
      port_d    = '0;
      vld_d[0]  = push_i;
      port_d[0] = port_i;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         port_d[i] = port_q[i-1];
      end
   end

   // Only the valid bits need clearing; a stale port bit is harmless.
   dff #(.W(RD_LAT), .RST_VAL('0)) u_vld_dff (
      .clk (clk),
      .rst (rst),
      .d_i (vld_d),
      .q_o (vld_q)
   );

   dff #(.W(RD_LAT), .RST_VAL('0)) u_port_dff (
      .clk (clk),
      .rst (1'b0),
      .d_i (port_d),
      .q_o (port_q)
   );

   assign pop_vld_o  = vld_q[RD_LAT-1];
   assign pop_port_o = port_q[RD_LAT-1];
   assign empty_o    = ~|vld_q;

endmodule : rd_tag_pipe

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing one banked main memory between the I-cache
// controller (port 0) and the D-cache controller (port 1). A grant is held
// for a full line transaction (while req stays high); the memory pipeline is
// drained before ownership can change, and read-data valid strobes are
// steered back to the port that issued each read.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_0/1                    transaction request, held for whole line txn
//   rd_0/1, wr_0/1             access strobes (rd+wr together counts as wr)
//   addr_0/1, wdata_0/1        access address / write data
//   gnt_0/1                    port owns memory this cycle
//   stall_0/1                  requester must hold its access and retry
//   rd_valid_0/1               rdata carries this port's read data
//   rdata                      broadcast copy of mem_data_out
//   mem_rd, mem_wr             gated access strobes to memory
//   mem_addr, mem_wdata        owner's address / write data
//   mem_stall                  memory rejected this cycle's access
//   mem_busy                   per-bank busy flags
//   mem_data_out               memory read data
// ----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = 2,
   parameter int NBANK  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_0,
   input  logic             req_1,
   input  logic             rd_0,
   input  logic             rd_1,
   input  logic             wr_0,
   input  logic             wr_1,
   input  logic [AW-1:0]    addr_0,
   input  logic [AW-1:0]    addr_1,
   input  logic [DW-1:0]    wdata_0,
   input  logic [DW-1:0]    wdata_1,
   output logic             gnt_0,
   output logic             gnt_1,
   output logic             stall_0,
   output logic             stall_1,
   output logic             rd_valid_0,
   output logic             rd_valid_1,
   output logic [DW-1:0]    rdata,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic             mem_stall,
   input  logic [NBANK-1:0] mem_busy,
   input  logic [DW-1:0]    mem_data_out
);

   arb_state_e state_q, state_d;
   logic [1:0] state_raw_q;
   logic       last_q, last_d;

   logic       own_rd_0, own_rd_1, own_wr_0, own_wr_1;
   logic       tag_push, tag_port;
   logic       tag_pop_vld, tag_pop_port, tag_empty;

   // ---------------------------------------------------------------- state
   dff #(.W(2), .RST_VAL(ST_IDLE)) u_state_dff (
      .clk (clk),
      .rst (rst),
      .d_i (state_d),
      .q_o (state_raw_q)
   );
   assign state_q = arb_state_e'(state_raw_q);

   // last resets to port 1 so that port 0 wins the first tie.
   dff #(.W(1), .RST_VAL(PORT_DC)) u_last_dff (
      .clk (clk),
      .rst (rst),
      .d_i (last_d),
      .q_o (last_q)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_0 && req_1) state_d = (last_q == PORT_IC) ? ST_GNT1 : ST_GNT0;
            else if (req_0)     state_d = ST_GNT0;
            else if (req_1)     state_d = ST_GNT1;
         end
         ST_GNT0: begin
            if (!req_0) begin
               state_d = ST_DRAIN;
               last_d  = PORT_IC;
            end
         end
         ST_GNT1: begin
            if (!req_1) begin
               state_d = ST_DRAIN;
               last_d  = PORT_DC;
            end
         end
         ST_DRAIN: begin
            // Banks idle and no read data still owed to the old owner.
            if ((mem_busy == '0) && tag_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   assign gnt_0 = (state_q == ST_GNT0);
   assign gnt_1 = (state_q == ST_GNT1);

   // An access needs both ownership and a live request; wr dominates rd.
   assign own_wr_0 = gnt_0 & req_0 & wr_0;
   assign own_wr_1 = gnt_1 & req_1 & wr_1;
   assign own_rd_0 = gnt_0 & req_0 & rd_0 & ~wr_0;
   assign own_rd_1 = gnt_1 & req_1 & rd_1 & ~wr_1;

   assign mem_rd    = own_rd_0 | own_rd_1;
   assign mem_wr    = own_wr_0 | own_wr_1;
   assign mem_addr  = gnt_0 ? addr_0  : (gnt_1 ? addr_1  : '0);
   assign mem_wdata = gnt_0 ? wdata_0 : (gnt_1 ? wdata_1 : '0);

   assign stall_0 = req_0 & ~(gnt_0 & ~mem_stall);
   assign stall_1 = req_1 & ~(gnt_1 & ~mem_stall);

   // ---------------------------------------------------------------- read tags
   assign tag_push = mem_rd & ~mem_stall;
   assign tag_port = gnt_1 ? PORT_DC : PORT_IC;

   rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
      .clk        (clk),
      .rst        (rst),
      .push_i     (tag_push),
      .port_i     (tag_port),
      .pop_vld_o  (tag_pop_vld),
      .pop_port_o (tag_pop_port),
      .empty_o    (tag_empty)
   );

   assign rd_valid_0 = tag_pop_vld & (tag_pop_port == PORT_IC);
   assign rd_valid_1 = tag_pop_vld & (tag_pop_port == PORT_DC);
   assign rdata      = mem_data_out;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int RD_LAT = 2;
   localparam int NBANK = 4;

   logic clk = 1'b0;
   logic rst;
   logic req_0, req_1, rd_0, rd_1, wr_0, wr_1;
   logic [AW-1:0] addr_0, addr_1;
   logic [DW-1:0] wdata_0, wdata_1;
   logic gnt_0, gnt_1, stall_0, stall_1, rd_valid_0, rd_valid_1;
   logic [DW-1:0] rdata;
   logic mem_rd, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic mem_stall;
   logic [NBANK-1:0] mem_busy;
   logic [DW-1:0] mem_data_out;

   int n_checks = 0;
   int n_fail   = 0;
   int n_wr     = 0;
   int n_rv0    = 0;
   int n_rv1    = 0;

   typedef struct {
      logic          port;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .NBANK(NBANK)) dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .req_1(req_1), .rd_0(rd_0), .rd_1(rd_1),
      .wr_0(wr_0), .wr_1(wr_1), .addr_0(addr_0), .addr_1(addr_1),
      .wdata_0(wdata_0), .wdata_1(wdata_1),
      .gnt_0(gnt_0), .gnt_1(gnt_1), .stall_0(stall_0), .stall_1(stall_1),
      .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1), .rdata(rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_stall(mem_stall), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
   );

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // Memory model: data for an accepted read returns RD_LAT cycles later.
   logic          ml_v0 = 1'b0, ml_v1 = 1'b0;
   logic [AW-1:0] ml_a0 = '0,   ml_a1 = '0;
   always @(posedge clk) begin
      ml_v0 <= mem_rd & ~mem_stall;
      ml_a0 <= mem_addr;
      ml_v1 <= ml_v0;
      ml_a1 <= ml_a0;
   end
   assign mem_data_out = ml_v1 ? mem_f(ml_a1) : '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every rd_valid must match the oldest expected read.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_wr && !mem_stall) n_wr++;
         if (rd_valid_0 || rd_valid_1) begin
            if (rd_valid_1) n_rv1++;
            else            n_rv0++;
            check_eq("rv_onehot", {31'd0, rd_valid_0 & rd_valid_1}, 0);
            if (sb.size() == 0) begin
               check_eq("rv_unexpected", {30'd0, rd_valid_1, rd_valid_0}, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("rv_port", {31'd0, rd_valid_1}, {31'd0, e.port});
               check_eq("rdata", {16'd0, rdata}, {16'd0, e.data});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_rd(input bit p, input logic [AW-1:0] a, output int waited);
      bit done;
      done   = 1'b0;
      waited = 0;
      if (p) begin rd_1 = 1'b1; wr_1 = 1'b0; addr_1 = a; end
      else   begin rd_0 = 1'b1; wr_0 = 1'b0; addr_0 = a; end
      while (!done && waited < 20) begin
         @(negedge clk);
         if ((p ? stall_1 : stall_0) == 1'b0) begin
            check_eq("rd_strobe", {31'd0, mem_rd}, 1);
            check_eq("rd_addr", {16'd0, mem_addr}, {16'd0, a});
            sb.push_back('{port: p, data: mem_f(a)});
            done = 1'b1;
         end else begin
            waited++;
         end
         tick();
      end
      check_eq("rd_accept", {31'd0, done}, 1);
   endtask

   task automatic wait_gnt(input bit p, input int max, output int waited);
      bit got;
      got    = 1'b0;
      waited = 0;
      while (!got && waited < max) begin
         @(negedge clk);
         if ((p ? gnt_1 : gnt_0) == 1'b1) got = 1'b1;
         else begin
            waited++;
            tick();
         end
      end
      check_eq(p ? "gnt1_arrive" : "gnt0_arrive", {31'd0, got}, 1);
   endtask

   task automatic idle_inputs();
      req_0 = 0; req_1 = 0; rd_0 = 0; rd_1 = 0; wr_0 = 0; wr_1 = 0;
      addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
      mem_stall = 0; mem_busy = '0;
   endtask

   initial begin
      int w, snap0, snap1, snapw;
      bit got;
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();

      // Reset state
      @(negedge clk);
      check_eq("rst_gnt", {30'd0, gnt_1, gnt_0}, 0);
      check_eq("rst_mem", {30'd0, mem_wr, mem_rd}, 0);
      check_eq("rst_rv", {30'd0, rd_valid_1, rd_valid_0}, 0);
      check_eq("rst_stall", {30'd0, stall_1, stall_0}, 0);
      check_eq("rst_addr", {16'd0, mem_addr}, 0);
      tick();
      req_0 = 1'b1;
      @(negedge clk);
      check_eq("rst_stall_req", {30'd0, stall_1, stall_0}, 32'd1);
      tick();
      rst = 1'b0;
      req_0 = 1'b0;
      tick();

      // Test 1: port 0 alone, four reads
      snap0 = n_rv0; snap1 = n_rv1;
      req_0 = 1'b1; rd_0 = 1'b1; addr_0 = 16'h0000;
      @(negedge clk);
      check_eq("t1_gnt_c0", {31'd0, gnt_0}, 0);
      check_eq("t1_stall_c0", {31'd0, stall_0}, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         do_rd(1'b0, 16'(2 * i), w);
         check_eq("t1_wait", w, 0);
      end
      rd_0 = 1'b0; req_0 = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      check_eq("t1_rv0_cnt", n_rv0 - snap0, 4);
      check_eq("t1_rv1_cnt", n_rv1 - snap1, 0);
      tick();

      // Test 2: simultaneous requests after reset
      rst = 1'b1; idle_inputs(); tick(); rst = 1'b0; sb.delete(); tick();
      req_0 = 1'b1; req_1 = 1'b1; rd_1 = 1'b1; addr_1 = 16'h0100; addr_0 = 16'h0040;
      @(negedge clk);
      check_eq("t2_stall_c0", {30'd0, stall_1, stall_0}, 3);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t2_gnt0", {30'd0, gnt_1, gnt_0}, 1);
         check_eq("t2_stall1", {31'd0, stall_1}, 1);
         check_eq("t2_no_rd", {31'd0, mem_rd}, 0);
         check_eq("t2_addr", {16'd0, mem_addr}, 32'h0040);
         tick();
      end
      req_0 = 1'b0; mem_busy = 4'b0100;
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t2_drain_gnt", {30'd0, gnt_1, gnt_0}, 0);
         check_eq("t2_drain_stall1", {31'd0, stall_1}, 1);
         check_eq("t2_drain_mem", {30'd0, mem_wr, mem_rd}, 0);
         tick();
      end
      mem_busy = '0;
      do_rd(1'b1, 16'h0100, w);
      check_eq("t2_drain_exit", {31'd0, (w >= 1) && (w <= 2)}, 1);
      rd_1 = 1'b0; req_1 = 1'b0;
      repeat (5) tick();

      // Test 3: repeated simultaneous requests alternate
      for (int r = 0; r < 4; r++) begin
         req_0 = 1'b1; req_1 = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (gnt_0 || gnt_1) got = 1'b1;
            else tick();
         end
         check_eq("t3_got", {31'd0, got}, 1);
         check_eq("t3_winner", {30'd0, gnt_1, gnt_0}, (r % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         req_0 = 1'b0; req_1 = 1'b0;
         repeat (3) tick();
      end

      // Test 4: owner write under mem_stall, rd+wr, access without req
      req_0 = 1'b1;
      wait_gnt(1'b0, 5, w);
      tick();
      snapw = n_wr;
      wr_0 = 1'b1; addr_0 = 16'h0010; wdata_0 = 16'hBEEF; mem_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("t4_stall", {31'd0, stall_0}, 1);
         check_eq("t4_wr", {31'd0, mem_wr}, 1);
         check_eq("t4_addr", {16'd0, mem_addr}, 32'h0010);
         tick();
      end
      mem_stall = 1'b0;
      @(negedge clk);
      check_eq("t4_stall_rel", {31'd0, stall_0}, 0);
      check_eq("t4_wdata", {16'd0, mem_wdata}, 32'hBEEF);
      tick();
      wr_0 = 1'b0;
      @(negedge clk);
      check_eq("t4_one_write", n_wr - snapw, 1);
      tick();
      rd_0 = 1'b1; wr_0 = 1'b1; addr_0 = 16'h0012;
      rd_1 = 1'b1; addr_1 = 16'h0099;
      @(negedge clk);
      check_eq("t4_rdwr_is_wr", {30'd0, mem_wr, mem_rd}, 2);
      check_eq("t4_noreq_nostall", {31'd0, stall_1}, 0);
      tick();
      rd_0 = 1'b0; wr_0 = 1'b0; rd_1 = 1'b0; req_0 = 1'b0;
      repeat (4) tick();

      // Test 5: owner drops with reads in flight and banks busy
      req_1 = 1'b1;
      wait_gnt(1'b1, 5, w);
      tick();
      req_0 = 1'b1;
      snap1 = n_rv1;
      do_rd(1'b1, 16'h0020, w);
      do_rd(1'b1, 16'h0022, w);
      rd_1 = 1'b0; req_1 = 1'b0; mem_busy = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t5_gnt0_held", {31'd0, gnt_0}, 0);
         check_eq("t5_stall0", {31'd0, stall_0}, 1);
         tick();
      end
      mem_busy = '0;
      wait_gnt(1'b0, 5, w);
      check_eq("t5_rv1_cnt", n_rv1 - snap1, 2);
      tick();
      req_0 = 1'b0;
      repeat (4) tick();

      // Test 6: reset mid-GNT1 with a read in flight
      req_1 = 1'b1;
      wait_gnt(1'b1, 5, w);
      tick();
      snap1 = n_rv1;
      do_rd(1'b1, 16'h0030, w);
      rst = 1'b1; rd_1 = 1'b0; req_1 = 1'b0;
      sb.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("t6_gnt", {30'd0, gnt_1, gnt_0}, 0);
      check_eq("t6_rv", {30'd0, rd_valid_1, rd_valid_0}, 0);
      repeat (5) tick();
      @(negedge clk);
      check_eq("t6_no_stale", n_rv1 - snap1, 0);
      check_eq("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_arbiter
